// File: rtl/reg_burst_arbiter_pkg.sv
// Shared definitions for the register-file burst arbiter. This file holds the
// state encodings, requester and direction constants, and the small helpers
// used by the top level.
package reg_burst_arbiter_pkg;

    localparam int DEF_REG_W = 5;
    localparam int DEF_LEN_W = 3;

    localparam int REQ0 = 0;
    localparam int REQ1 = 1;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } burstState_e;

    // Convert a requester index to its one-hot grant/done bit.
    function automatic logic [1:0] ownerOneHot(input logic owner);
        return owner ? 2'b10 : 2'b01;
    endfunction

    // Round-robin pick. A lone requester wins outright. On a tie, the winner
    // is the requester that did not own the previous burst.
    function automatic logic pickOwner(input logic [1:0] req, input logic last);
        logic winner;
        winner = 1'(REQ0);
        case (req)
            2'b01:   winner = 1'(REQ0);
            2'b10:   winner = 1'(REQ1);
            2'b11:   winner = ~last;
            default: winner = 1'(REQ0);
        endcase
        return winner;
    endfunction

endpackage

// File: rtl/reg_burst_arbiter_seq.sv
// Loadable regnum sequencer. On load, it captures the base regnum, the burst
// length and the direction. On each step, it advances the regnum by +1 or -1.
// The advance is modulo 2^REG_W, so the regnum wraps in both directions.
// lastBeat flags the final write of the burst.
module reg_burst_seq
    import reg_burst_arbiter_pkg::*;
#(
    parameter int REG_W = DEF_REG_W,
    parameter int LEN_W = DEF_LEN_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [REG_W-1:0] base,
    input  logic [LEN_W-1:0] len,
    input  logic             dir,
    output logic [REG_W-1:0] cur,
    output logic             lastBeat
);

    logic [LEN_W-1:0] cnt;
    logic             d;
    logic [REG_W-1:0] nextCur;

    // Next regnum in the latched direction. The add/subtract wraps naturally.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        nextCur = cur;
        case (d)
            DIR_UP:   nextCur = cur + 1'b1;
            DIR_DOWN: nextCur = cur - 1'b1;
            default:  nextCur = cur;
        endcase
    end

    // Capture the burst on load, then count it down one beat per step.
    always_ff @(posedge clock) begin
        // NOTE: these are control-visible datapath registers, not a memory array, so they are reset along with the FSM.
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            cur <= '0;
            cnt <= '0;
            d   <= DIR_UP;
        end else if (load) begin
            cur <= base;
            cnt <= len;
            d   <= dir;
        end else if (step) begin
            cur <= nextCur;
            cnt <= cnt - 1'b1;
        end
    end

    assign lastBeat = (cnt == '0);

endmodule

// File: rtl/reg_burst_arbiter.sv
// The burst arbiter shares the register-file write port between two
// requesters. It picks an owner round-robin and then sequences that owner's
// burst of writes. After the last write, it pulses done to the owner for one
// cycle.
module reg_burst_arbiter
    import reg_burst_arbiter_pkg::*;
#(
    parameter int REG_W = DEF_REG_W,
    parameter int LEN_W = DEF_LEN_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [1:0]       dir,
    input  logic [REG_W-1:0] base0,
    input  logic [REG_W-1:0] base1,
    input  logic [LEN_W-1:0] len0,
    input  logic [LEN_W-1:0] len1,
    output logic [1:0]       grant,
    output logic             wr_en,
    output logic [REG_W-1:0] wr_reg,
    output logic [1:0]       done,
    output logic             busy
);

    burstState_e      state;
    burstState_e      nextState;
    logic             owner;
    logic             last;
    logic             newOwner;
    logic             load;
    logic             step;
    logic [REG_W-1:0] selBase;
    logic [LEN_W-1:0] selLen;
    logic             selDir;
    logic [REG_W-1:0] cur;
    logic             lastBeat;

    assign newOwner = pickOwner(req, last);
    assign load     = (state == IDLE) && (req != 2'b00);
    assign step     = (state == BURST);
    assign selBase  = newOwner ? base1 : base0;
    assign selLen   = newOwner ? len1  : len0;
    assign selDir   = dir[newOwner];

    reg_burst_seq #(
        .REG_W (REG_W),
        .LEN_W (LEN_W)
    ) uSeq (
        .clock    (clock),
        .reset    (reset),
        .load     (load),
        .step     (step),
        .base     (selBase),
        .len      (selLen),
        .dir      (selDir),
        .cur      (cur),
        .lastBeat (lastBeat)
    );

    // Register the state, the burst owner and the round-robin pointer.
    // last starts at 1 so that requester 0 wins the first tie.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
            owner <= 1'(REQ0);
            last  <= 1'(REQ1);
        end else begin
            state <= nextState;
            if (load) begin
                owner <= newOwner;
            end
            if (state == DONE) begin
                last <= owner;
            end
        end
    end

    // Compute the next state and the state-decoded outputs.
    // wr_reg is forced to 0 whenever no write is happening.
    always_comb begin
        nextState = state;
        grant     = 2'b00;
        wr_en     = 1'b0;
        wr_reg    = '0;
        done      = 2'b00;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (req != 2'b00) begin
                    nextState = BURST;
                end
            end
            BURST: begin
                busy   = 1'b1;
                grant  = ownerOneHot(owner);
                wr_en  = 1'b1;
                wr_reg = cur;
                if (lastBeat) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                grant     = ownerOneHot(owner);
                done      = ownerOneHot(owner);
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

endmodule
